acu_issue_pipe: RTL and testbench
=================================

Name: acu_issue_pipe

Overview:
- Parametrised successor to the single-cycle ALU/CMP array.
- Each cycle, selects up to LANES ready reservation-station slots by round-robin.
- Executes each selected slot's ALU or compare op in a registered pipeline of STAGES stages.
- Returns results with their ROB tag under a valid/ready handshake; supports stall and flush. Sits between the reservation station and the CDB arbiter.

Parameters:
- SIZE, 8: number of reservation-station slots; power of two, ≥2.
- LANES, 2: parallel execution lanes; 1 ≤ LANES ≤ SIZE.
- STAGES, 2: result pipeline depth in cycles; ≥1.
- XLEN, 32: operand/result width.
- TAG_W, 4: ROB tag width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  kill all in-flight results.
- slot_valid  in  SIZE  slot holds an issuable op.
- slot_is_cmp  in  SIZE  1 = compare op, 0 = ALU op.
- slot_funct  in  SIZE×4  ALU: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and; CMP: 0 beq, 1 bne, 4 blt, 5 bge, 6 bltu, 7 bgeu.
- slot_a, slot_b  in  SIZE×XLEN  operands.
- slot_tag  in  SIZE×TAG_W  ROB tag.
- issue_ack  out  SIZE  combinational; slot granted this cycle, RS frees it at the edge.
- out_valid  out  LANES  result valid per lane.
- out_data  out  LANES×XLEN  result; compare ops return {XLEN-1 zeros, taken}.
- out_tag  out  LANES×TAG_W  tag of result.
- out_ready  in  1  consumer accepts all valid lanes this cycle.

Behaviour:
- Arbitration:
  - Scan slots from rr_ptr upward, modulo SIZE.
  - Grant the first min(LANES, #valid) slots with slot_valid=1.
  - Grant k (in scan order) goes to lane k.
  - At most one grant per slot; issue_ack is one-hot per grant.
- rr_ptr update:
  - On a cycle with ≥1 grant: rr_ptr ← (index of last granted slot + 1) mod SIZE.
  - Otherwise rr_ptr is held.
- Grant suppression: no grants while rst=0, flush=1, or the pipeline is stalled.
- Stall:
  - stall = any out_valid=1 and out_ready=0.
  - On stall, every stage register holds and issue_ack=0.
  - No bubble squeezing.
- Execute and latency:
  - Operands of a granted slot are computed combinationally in stage 1 and registered at the edge.
  - A grant in cycle t with no stalls gives out_valid in cycle t+STAGES.
  - Stages 2..STAGES are pure delay registers.
  - Throughput is LANES results/cycle when out_ready=1.
- Arithmetic:
  - add/sub wrap modulo 2^XLEN.
  - Shift amount is slot_b[$clog2(XLEN)-1:0].
  - sra is arithmetic; slt/blt/bge are signed; sltu/bltu/bgeu are unsigned.
  - Undefined funct codes produce 0 with valid asserted.
- Flush:
  - Clears every stage valid bit at the edge; data/tag are don't-care.
  - issue_ack=0 in the flush cycle; rr_ptr is held.
  - Flush overrides stall.
  - out_valid=0 the cycle after flush.
- Reset (rst=0 at an edge):
  - All stage valid bits ← 0, rr_ptr ← 0.
  - Outputs: out_valid=0, out_data=0, out_tag=0.
  - issue_ack=0 while rst=0.
  - Reset mid-operation discards all in-flight results.
- Simultaneous stall release and new grant: when out_ready=1, the pipeline advances and new grants enter stage 1 in the same cycle.
- Lane ordering: unfilled lanes carry valid=0; a partial issue leaves upper lanes idle.

Test Plan:
- Reset then slot_valid=8'h0F, all add with a=5, b=7, LANES=2:
  - cycle 0: issue_ack=8'h03;
  - cycle 1: issue_ack=8'h0C;
  - out_data=12 on both lanes at cycles 2 and 3, tags matching slots;
  - rr_ptr=4 at the end.
- Round-robin wrap: rr_ptr=6, slot_valid=8'hC1 → issue_ack=8'h40|8'h80 (slots 6, 7); next cycle slot 0 granted, rr_ptr=1.
- Arithmetic corners (each result checked at t+STAGES):
  - sub 0−1 = 32'hFFFFFFFF;
  - sra 32'h80000000 by 31 = 32'hFFFFFFFF;
  - slt −1<1 = 1; sltu 32'hFFFFFFFF<1 = 0;
  - blt −2,3 → 1; bgeu 1,32'hFFFFFFFF → 0.
- Stall: hold out_ready=0 for 3 cycles with results valid:
  - out_valid/out_data stable for the duration;
  - issue_ack=0 although slot_valid=8'hFF;
  - on release, the held result is accepted and a new grant issues in the same cycle.
- Flush with 2 stages full plus a pending grant: issue_ack=0 that cycle; out_valid=0 for the next STAGES cycles; rr_ptr unchanged.
- Mid-stream reset: rst=0 for one cycle while results are in flight → all outputs 0 next cycle, rr_ptr=0, no stale result emerges afterwards.

Source files
------------

// File: rtl/acu_issue_pipe.sv
// rtl/acu_issue_pipe.sv - round-robin multi-lane ALU/CMP issue with a stallable result pipeline
module acu_issue_pipe #(
  parameter int SIZE   = 8,
  parameter int LANES  = 2,
  parameter int STAGES = 2,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [SIZE-1:0]        slot_valid,
  input  logic [SIZE-1:0]        slot_is_cmp,
  input  logic [SIZE*4-1:0]      slot_funct,
  input  logic [SIZE*XLEN-1:0]   slot_a,
  input  logic [SIZE*XLEN-1:0]   slot_b,
  input  logic [SIZE*TAG_W-1:0]  slot_tag,
  output logic [SIZE-1:0]        issue_ack,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*XLEN-1:0]  out_data,
  output logic [LANES*TAG_W-1:0] out_tag,
  input  logic                   out_ready
);

  localparam int IDX_W = $clog2(SIZE);
  localparam int SH_W  = $clog2(XLEN);

  function automatic logic [XLEN-1:0] f_exec(input logic is_cmp, input logic [3:0] funct,
                                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [SH_W-1:0] sh;
    logic            taken;
    logic [XLEN-1:0] res;
    sh    = b[SH_W-1:0];
    taken = 1'b0;
    res   = '0;
    if (is_cmp) begin
      case (funct)
        4'd0:    taken = (a == b);
        4'd1:    taken = (a != b);
        4'd4:    taken = ($signed(a) <  $signed(b));
        4'd5:    taken = ($signed(a) >= $signed(b));
        4'd6:    taken = (a <  b);
        4'd7:    taken = (a >= b);
        default: taken = 1'b0;
      endcase
      res = {{(XLEN-1){1'b0}}, taken};
    end else begin
      case (funct)
        4'd0:    res = a + b;
        4'd1:    res = a - b;
        4'd2:    res = a << sh;
        4'd3:    res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
        4'd4:    res = {{(XLEN-1){1'b0}}, (a < b)};
        4'd5:    res = a ^ b;
        4'd6:    res = a >> sh;
        4'd7:    res = $signed(a) >>> sh;
        4'd8:    res = a | b;
        4'd9:    res = a & b;
        default: res = '0;
      endcase
    end
    return res;
  endfunction

  logic [IDX_W-1:0] r_rr_ptr;
  logic [LANES-1:0] r_vld  [STAGES];
  logic [XLEN-1:0]  r_data [STAGES][LANES];
  logic [TAG_W-1:0] r_tag  [STAGES][LANES];

  logic [3:0]       w_funct [SIZE];
  logic [XLEN-1:0]  w_a     [SIZE];
  logic [XLEN-1:0]  w_b     [SIZE];
  logic [TAG_W-1:0] w_tag   [SIZE];

  logic             w_stall;
  logic             w_grant_en;
  logic [SIZE-1:0]  w_ack;
  logic [IDX_W-1:0] w_last;
  logic [LANES-1:0] w_lane_vld;
  logic [IDX_W-1:0] w_lane_idx [LANES];
  logic [XLEN-1:0]  w_res      [LANES];
  logic [TAG_W-1:0] w_res_tag  [LANES];

  always_comb begin
    for (int s = 0; s < SIZE; s++) begin
      w_funct[s] = slot_funct[s*4 +: 4];
      w_a[s]     = slot_a[s*XLEN +: XLEN];
      w_b[s]     = slot_b[s*XLEN +: XLEN];
      w_tag[s]   = slot_tag[s*TAG_W +: TAG_W];
    end
  end

  assign w_stall    = |(r_vld[STAGES-1] & ~{LANES{out_ready}});
  assign w_grant_en = rst & ~flush & ~w_stall;

  // Scan from rr_ptr; the k-th valid slot found goes to lane k.
  always_comb begin
    logic [IDX_W-1:0] idx;
    int               cnt;
    idx        = '0;
    cnt        = 0;
    w_ack      = '0;
    w_last     = r_rr_ptr;
    w_lane_vld = '0;
    for (int l = 0; l < LANES; l++) w_lane_idx[l] = '0;
    for (int p = 0; p < SIZE; p++) begin
      idx = r_rr_ptr + IDX_W'(p);
      if (w_grant_en && slot_valid[idx] && cnt < LANES) begin
        w_ack[idx] = 1'b1;
        for (int l = 0; l < LANES; l++) begin
          if (l == cnt) begin
            w_lane_vld[l] = 1'b1;
            w_lane_idx[l] = idx;
          end
        end
        w_last = idx;
        cnt    = cnt + 1;
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_res[l]     = f_exec(slot_is_cmp[w_lane_idx[l]], w_funct[w_lane_idx[l]],
                            w_a[w_lane_idx[l]], w_b[w_lane_idx[l]]);
      w_res_tag[l] = w_tag[w_lane_idx[l]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_ptr <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_vld[s] <= '0;
        for (int l = 0; l < LANES; l++) begin
          r_data[s][l] <= '0;
          r_tag[s][l]  <= '0;
        end
      end
    end else begin
      if (|w_ack) r_rr_ptr <= w_last + IDX_W'(1);
      if (flush) begin
        for (int s = 0; s < STAGES; s++) r_vld[s] <= '0;
      end else if (!w_stall) begin
        r_vld[0] <= w_lane_vld;
        for (int l = 0; l < LANES; l++) begin
          r_data[0][l] <= w_res[l];
          r_tag[0][l]  <= w_res_tag[l];
        end
        for (int s = 1; s < STAGES; s++) begin
          r_vld[s] <= r_vld[s-1];
          for (int l = 0; l < LANES; l++) begin
            r_data[s][l] <= r_data[s-1][l];
            r_tag[s][l]  <= r_tag[s-1][l];
          end
        end
      end
    end
  end

  assign issue_ack = w_ack;
  assign out_valid = r_vld[STAGES-1];

  always_comb begin
    out_data = '0;
    out_tag  = '0;
    for (int l = 0; l < LANES; l++) begin
      out_data[l*XLEN +: XLEN]   = r_data[STAGES-1][l];
      out_tag[l*TAG_W +: TAG_W]  = r_tag[STAGES-1][l];
    end
  end

endmodule

// File: tb/tb_acu_issue_pipe.sv
// tb/tb_acu_issue_pipe.sv - directed scoreboard bench for acu_issue_pipe
module tb_acu_issue_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, out_ready;
  logic [7:0]  slot_valid, slot_is_cmp, issue_ack;
  logic [31:0] slot_funct;
  logic [255:0] slot_a, slot_b;
  logic [31:0] slot_tag;
  logic [1:0]  out_valid;
  logic [63:0] out_data;
  logic [7:0]  out_tag;

  acu_issue_pipe dut (
    .clk(clk), .rst(rst), .flush(flush),
    .slot_valid(slot_valid), .slot_is_cmp(slot_is_cmp), .slot_funct(slot_funct),
    .slot_a(slot_a), .slot_b(slot_b), .slot_tag(slot_tag),
    .issue_ack(issue_ack), .out_valid(out_valid), .out_data(out_data),
    .out_tag(out_tag), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] d; logic [3:0] t; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;

  logic [7:0]  sv, scmp;
  logic [3:0]  sf [8];
  logic [3:0]  st [8];
  logic [31:0] sa [8];
  logic [31:0] sb [8];
  logic [31:0] sexp [8];

  int          n_pass = 0;
  int          n_total = 0;
  int          m_rr = 0;
  logic        mon_en = 1'b0;
  logic [1:0]  last_ov;
  logic [63:0] last_od;
  logic [7:0]  last_ot;

  always_comb begin
    slot_valid  = sv;
    slot_is_cmp = scmp;
    for (int i = 0; i < 8; i++) begin
      slot_funct[i*4 +: 4] = sf[i];
      slot_tag[i*4 +: 4]   = st[i];
      slot_a[i*32 +: 32]   = sa[i];
      slot_b[i*32 +: 32]   = sb[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic set_slot(input int i, input logic c, input logic [3:0] f,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    scmp[i] = c; sf[i] = f; sa[i] = a; sb[i] = b; sexp[i] = e; st[i] = 4'(i + 3);
  endtask

  task automatic all_add();
    for (int i = 0; i < 8; i++) set_slot(i, 1'b0, 4'd0, 32'd5, 32'd7, 32'd12);
  endtask

  // One cycle: check grants, push expected results in lane order, then let the RS free granted slots.
  task automatic step(input logic [7:0] exp_ack);
    int   lane;
    int   idx;
    int   last;
    exp_t e;
    lane = 0; last = m_rr;
    @(negedge clk);
    chk("issue_ack", 64'(issue_ack), 64'(exp_ack));
    last_ov = out_valid; last_od = out_data; last_ot = out_tag;
    for (int k = 0; k < 8; k++) begin
      idx = (m_rr + k) % 8;
      if (exp_ack[idx]) begin
        e.d = sexp[idx]; e.t = st[idx];
        if (lane == 0) q0.push_back(e); else q1.push_back(e);
        lane++; last = idx;
      end
    end
    if (exp_ack != 8'h00) m_rr = (last + 1) % 8;
    @(posedge clk); #1;
    sv = sv & ~exp_ack;
  endtask

  always @(negedge clk) begin
    if (mon_en && out_ready === 1'b1) begin
      if (out_valid[0] === 1'b1) begin
        if (q0.size() == 0) chk("lane0_unexpected", 64'(out_valid[0]), 64'd0);
        else begin
          mon_e = q0.pop_front();
          chk("lane0_data", 64'(out_data[31:0]), 64'(mon_e.d));
          chk("lane0_tag", 64'(out_tag[3:0]), 64'(mon_e.t));
        end
      end
      if (out_valid[1] === 1'b1) begin
        if (q1.size() == 0) chk("lane1_unexpected", 64'(out_valid[1]), 64'd0);
        else begin
          mon_e = q1.pop_front();
          chk("lane1_data", 64'(out_data[63:32]), 64'(mon_e.d));
          chk("lane1_tag", 64'(out_tag[7:4]), 64'(mon_e.t));
        end
      end
    end
  end

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1; sv = 8'hFF; scmp = 8'h00;
    all_add();
    @(posedge clk); #1;
    step(8'h00);
    chk("reset_out_valid", 64'(last_ov), 64'd0);
    chk("reset_out_data", last_od, 64'd0);
    chk("reset_out_tag", 64'(last_ot), 64'd0);

    rst = 1'b1; mon_en = 1'b1; sv = 8'h0F;
    step(8'h03);
    step(8'h0C);
    step(8'h00);
    chk("lat_valid_c2", 64'(last_ov), 64'h3);
    chk("lat_data_c2", last_od, {32'd12, 32'd12});
    step(8'h00);
    chk("lat_valid_c3", 64'(last_ov), 64'h3);
    step(8'h00);
    chk("lat_valid_c4", 64'(last_ov), 64'h0);
    sv = 8'hFF;
    step(8'h30);

    sv = 8'hC1;
    step(8'hC0);
    step(8'h01);
    sv = 8'h00;
    step(8'h00); step(8'h00);

    set_slot(0, 1'b0, 4'd1,  32'h0,        32'h1,        32'hFFFFFFFF);
    set_slot(1, 1'b0, 4'd7,  32'h80000000, 32'd31,       32'hFFFFFFFF);
    set_slot(2, 1'b0, 4'd3,  32'hFFFFFFFF, 32'h1,        32'h1);
    set_slot(3, 1'b0, 4'd4,  32'hFFFFFFFF, 32'h1,        32'h0);
    set_slot(4, 1'b1, 4'd4,  32'hFFFFFFFE, 32'h3,        32'h1);
    set_slot(5, 1'b1, 4'd7,  32'h1,        32'hFFFFFFFF, 32'h0);
    set_slot(6, 1'b0, 4'd12, 32'd5,        32'd7,        32'h0);
    set_slot(7, 1'b0, 4'd2,  32'h1,        32'd33,       32'h2);
    sv = 8'hFF;
    step(8'h06); step(8'h18); step(8'h60); step(8'h81);
    sv = 8'h00;
    step(8'h00); step(8'h00); step(8'h00);

    all_add();
    sv = 8'h06;
    step(8'h06);
    step(8'h00);
    out_ready = 1'b0; sv = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step(8'h00);
      chk("stall_valid", 64'(last_ov), 64'h3);
      chk("stall_data", last_od, {32'd12, 32'd12});
      chk("stall_tag", 64'(last_ot), {56'd0, 4'd5, 4'd4});
    end
    out_ready = 1'b1;
    step(8'h18);
    sv = 8'h00;
    step(8'h00); step(8'h00); step(8'h00);

    sv = 8'h60;
    step(8'h60);
    sv = 8'h81;
    step(8'h81);
    out_ready = 1'b0; flush = 1'b1; sv = 8'hFF;
    step(8'h00);
    q0.delete(); q1.delete();
    flush = 1'b0; out_ready = 1'b1; sv = 8'h00;
    step(8'h00);
    chk("flush_valid_1", 64'(last_ov), 64'h0);
    step(8'h00);
    chk("flush_valid_2", 64'(last_ov), 64'h0);
    sv = 8'hFF;
    step(8'h06);
    sv = 8'h00;
    step(8'h00); step(8'h00); step(8'h00);

    sv = 8'h18;
    step(8'h18);
    rst = 1'b0; sv = 8'hFF;
    step(8'h00);
    q0.delete(); q1.delete(); m_rr = 0;
    rst = 1'b1;
    step(8'h03);
    chk("midrst_valid", 64'(last_ov), 64'h0);
    chk("midrst_data", last_od, 64'd0);
    chk("midrst_tag", 64'(last_ot), 64'd0);
    sv = 8'h00;
    step(8'h00); step(8'h00); step(8'h00);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
